// File: rtl/iic_arb_pkg.sv
// iic_arb_pkg: shared types and defaults for the I2C register-access arbiter
package iic_arb_pkg;

    localparam int RST_LEN_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        RESP,
        RECOVER
    } iic_arb_state_t;

    typedef struct packed {
        logic [6:0] dev_addr;
        logic [7:0] reg_addr;
        logic       w;
        logic [7:0] wd;
    } iic_req_t;

endpackage

// File: rtl/iic_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first set request after last
module rr_pick #(
    parameter int N  = 4,
    parameter int GW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last,
    output logic          valid,
    output logic [GW-1:0] g
);

    logic [GW-1:0] idx;

    // scan from farthest to nearest so the nearest set bit after last wins
    always_comb begin
        valid = |req;
        g     = '0;
        idx   = '0;
        for (int i = N; i >= 1; i--) begin
            idx = GW'((int'(last) + i) % N);
            if (req[idx]) g = idx;
        end
    end

endmodule

// File: rtl/iic_arbiter.sv
// iic_arbiter: round-robin sharing of one iic_master among N register clients
module iic_arbiter
    import iic_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 1000000,
    parameter int RST_LEN = RST_LEN_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [N-1:0]   req,
    input  logic [N*7-1:0] req_dev_addr,
    input  logic [N*8-1:0] req_reg_addr,
    input  logic [N-1:0]   req_w,
    input  logic [N*8-1:0] req_wd,
    output logic [N-1:0]   ack,
    output logic [N-1:0]   err,
    output logic [7:0]     rdata,
    output logic           busy,
    output logic           m_start,
    output logic [6:0]     m_dev_addr,
    output logic [7:0]     m_reg_addr,
    output logic           m_w,
    output logic [7:0]     m_wd,
    input  logic [7:0]     m_rdata,
    input  logic           m_done,
    output logic           m_rst_n
);

    localparam int GW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT + 1);

    iic_arb_state_t state_q, state_d;
    logic [GW-1:0]  g_q, g_d, last_q, last_d, pick_g;
    logic [CW-1:0]  cnt_q, cnt_d;
    iic_req_t       fld_q, fld_d, sel;
    logic [7:0]     rdata_q, rdata_d;
    logic [N-1:0]   ack_q, ack_d, err_q, err_d;
    logic           m_start_q, m_start_d, m_rst_n_q, m_rst_n_d, busy_q, busy_d;
    logic           pick_valid;

    rr_pick #(.N(N), .GW(GW)) u_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .g     (pick_g)
    );

    // fields of the client the selector currently points at
    always_comb begin
        sel.dev_addr = req_dev_addr[int'(pick_g)*7 +: 7];
        sel.reg_addr = req_reg_addr[int'(pick_g)*8 +: 8];
        sel.w        = req_w[pick_g];
        sel.wd       = req_wd[int'(pick_g)*8 +: 8];
    end

    // next state and next registered outputs; the counter times WAIT and then RECOVER
    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        fld_d     = fld_q;
        rdata_d   = rdata_q;
        ack_d     = '0;
        err_d     = '0;
        m_start_d = 1'b0;
        m_rst_n_d = 1'b1;
        case (state_q)
            IDLE: if (en && pick_valid) begin
                state_d   = START;
                g_d       = pick_g;
                fld_d     = sel;
                m_start_d = 1'b1;
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (m_done) begin
                rdata_d    = m_rdata;
                ack_d[g_q] = 1'b1;
                state_d    = RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                err_d[g_q] = 1'b1;
                cnt_d      = '0;
                state_d    = RECOVER;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            RESP: begin
                last_d  = g_q;
                state_d = IDLE;
            end
            RECOVER: begin
                last_d = g_q;
                if (cnt_q == CW'(RST_LEN)) begin
                    state_d = IDLE;
                end else begin
                    m_rst_n_d = 1'b0;
                    cnt_d     = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            g_q       <= '0;
            last_q    <= GW'(N - 1);
            cnt_q     <= '0;
            fld_q     <= '0;
            rdata_q   <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            m_start_q <= 1'b0;
            m_rst_n_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            fld_q     <= fld_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            m_start_q <= m_start_d;
            m_rst_n_q <= m_rst_n_d;
            busy_q    <= busy_d;
        end
    end

    assign ack        = ack_q;
    assign err        = err_q;
    assign rdata      = rdata_q;
    assign busy       = busy_q;
    assign m_start    = m_start_q;
    assign m_dev_addr = fld_q.dev_addr;
    assign m_reg_addr = fld_q.reg_addr;
    assign m_w        = fld_q.w;
    assign m_wd       = fld_q.wd;
    assign m_rst_n    = m_rst_n_q;

endmodule

// File: tb/tb_iic_arbiter.sv
// tb_iic_arbiter: randomized bench with a transaction-timeline reference model
module tb_iic_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 50;
    localparam int RST_LEN = 4;
    localparam int INF     = 1 << 30;

    logic           clk = 1'b0;
    logic           rst_n, en, m_done, m_start, m_rst_n, busy, m_w;
    logic [N-1:0]   req, req_w, ack, err;
    logic [N*7-1:0] req_dev_addr;
    logic [N*8-1:0] req_reg_addr, req_wd;
    logic [7:0]     rdata, m_reg_addr, m_wd, m_rdata;
    logic [6:0]     m_dev_addr;

    iic_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .RST_LEN(RST_LEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .req          (req),
        .req_dev_addr (req_dev_addr),
        .req_reg_addr (req_reg_addr),
        .req_w        (req_w),
        .req_wd       (req_wd),
        .ack          (ack),
        .err          (err),
        .rdata        (rdata),
        .busy         (busy),
        .m_start      (m_start),
        .m_dev_addr   (m_dev_addr),
        .m_reg_addr   (m_reg_addr),
        .m_w          (m_w),
        .m_wd         (m_wd),
        .m_rdata      (m_rdata),
        .m_done       (m_done),
        .m_rst_n      (m_rst_n)
    );

    always #5 clk = ~clk;

    int         checks, errors, cyc;
    int         last_m, g_m, grant_cyc, free_cyc, start_cyc, ack_cyc, err_cyc, done_cyc, rlo, rhi;
    int         force_lat, force_rd;
    bit         hold_mode, rand_mode;
    logic [7:0] rdata_m, done_data, fr, fwd;
    logic [6:0] fd;
    logic       fw;
    int         acks[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_ref(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        last_m    = N - 1;
        g_m       = 0;
        grant_cyc = -10;
        free_cyc  = 0;
        start_cyc = -1;
        ack_cyc   = -1;
        err_cyc   = -1;
        done_cyc  = -1;
        rlo       = -5;
        rhi       = -5;
        rdata_m   = 8'h00;
    endtask

    task automatic set_client(input int i, input logic w, input logic [6:0] d, input logic [7:0] r, input logic [7:0] wd);
        req_w[i]              = w;
        req_dev_addr[i*7 +: 7] = d;
        req_reg_addr[i*8 +: 8] = r;
        req_wd[i*8 +: 8]       = wd;
        req[i]                = 1'b1;
    endtask

    task automatic set_random(input int i);
        set_client(i, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic reset_checks(input string p);
        chk({p, "_ack"}, ack, 0);
        chk({p, "_err"}, err, 0);
        chk({p, "_m_start"}, m_start, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_rdata"}, rdata, 0);
        chk({p, "_m_dev_addr"}, m_dev_addr, 0);
        chk({p, "_m_reg_addr"}, m_reg_addr, 0);
        chk({p, "_m_w"}, m_w, 0);
        chk({p, "_m_wd"}, m_wd, 0);
        chk({p, "_m_rst_n"}, m_rst_n, 1);
    endtask

    // one clock cycle: predict grant from inputs settled this cycle, then check and drive at negedge
    task automatic tick();
        int r, lat;
        bit bz;
        if (rst_n && en && req != 0 && cyc >= free_cyc) begin
            g_m       = rr_ref(last_m, req);
            grant_cyc = cyc;
            start_cyc = cyc + 1;
            free_cyc  = INF;
            fd        = req_dev_addr[g_m*7 +: 7];
            fr        = req_reg_addr[g_m*8 +: 8];
            fw        = req_w[g_m];
            fwd       = req_wd[g_m*8 +: 8];
        end
        @(negedge clk);
        cyc++;
        bz = cyc > grant_cyc && cyc < free_cyc;
        chk("m_start", m_start, cyc == start_cyc);
        chk("ack", ack, cyc == ack_cyc ? (1 << g_m) : 0);
        chk("err", err, cyc == err_cyc ? (1 << g_m) : 0);
        chk("busy", busy, bz);
        chk("m_rst_n", m_rst_n, !(cyc >= rlo && cyc <= rhi));
        if (cyc == ack_cyc) rdata_m = done_data;
        chk("rdata", rdata, rdata_m);
        if (bz) begin
            chk("m_dev_addr", m_dev_addr, fd);
            chk("m_reg_addr", m_reg_addr, fr);
            chk("m_w", m_w, fw);
            chk("m_wd", m_wd, fwd);
        end
        if (hold_mode)
            for (int i = 0; i < N; i++) if (ack[i]) acks.push_back(i);
        for (int i = 0; i < N; i++)
            if ((ack[i] || err[i]) && !hold_mode) req[i] = 1'b0;
        m_done = 1'b0;
        if (cyc == start_cyc) begin
            r = int'($urandom_range(0, 39));
            if (force_lat >= 0) lat = force_lat;
            else if (!rand_mode) lat = int'($urandom_range(1, 4));
            else lat = r == 0 ? TIMEOUT : r == 1 ? TIMEOUT + 1 : r == 2 ? 200 : int'($urandom_range(1, 6));
            force_lat = -1;
            done_data = force_rd >= 0 ? 8'(force_rd) : 8'($urandom);
            force_rd  = -1;
            done_cyc  = cyc + lat;
            if (done_cyc <= cyc + TIMEOUT) begin
                ack_cyc  = done_cyc + 1;
                free_cyc = done_cyc + 2;
            end else begin
                err_cyc  = cyc + TIMEOUT + 1;
                rlo      = err_cyc + 1;
                rhi      = err_cyc + RST_LEN;
                free_cyc = rhi + 1;
                if (done_cyc > err_cyc) done_cyc = -1;
            end
            last_m = g_m;
        end
        if (cyc == done_cyc) begin
            m_done  = 1'b1;
            m_rdata = done_data;
        end else if (rand_mode && !bz && $urandom_range(0, 9) == 0) begin
            m_done  = 1'b1;
            m_rdata = 8'($urandom);
        end
        if (rand_mode) begin
            if (cyc % 40 == 0) en = $urandom_range(0, 3) != 0;
            for (int i = 0; i < N; i++)
                if (!req[i] && $urandom_range(0, 5) == 0) set_random(i);
        end
    endtask

    task automatic settle(input int max);
        int n = 0;
        while ((req != 0 || cyc < free_cyc) && n < max) begin
            tick();
            n++;
        end
        chk("settle_req", req, 0);
    endtask

    initial begin
        int n;
        checks = 0; errors = 0; cyc = 0;
        rst_n = 1'b0; en = 1'b0; req = '0; req_w = '0;
        req_dev_addr = '0; req_reg_addr = '0; req_wd = '0;
        m_done = 1'b0; m_rdata = 8'h00;
        force_lat = -1; force_rd = -1; hold_mode = 0; rand_mode = 0;
        model_reset();
        repeat (3) tick();
        reset_checks("rst");
        rst_n = 1'b1;
        en    = 1'b1;
        tick();
        // client 0 write
        set_client(0, 1'b1, 7'h51, 8'h01, 8'hC0);
        force_lat = 3;
        settle(100);
        // client 2 read returning 0x37
        set_client(2, 1'b0, 7'h22, 8'h10, 8'h00);
        force_rd = 8'h37;
        settle(100);
        chk("t2_rdata", rdata, 8'h37);
        // move pointer to 3, then hold all four requests
        set_random(3);
        settle(100);
        hold_mode = 1;
        acks.delete();
        for (int i = 0; i < N; i++) set_random(i);
        n = 0;
        while (acks.size() < 5 && n < 300) begin
            tick();
            n++;
        end
        req = '0;
        hold_mode = 0;
        chk("rr_count", acks.size(), 5);
        for (int k = 0; k < acks.size() && k < 5; k++) chk("rr_order", acks[k], k % 4);
        settle(100);
        // timeout on client 1, client 3 pending behind it
        set_random(1);
        set_random(3);
        force_lat = 1000;
        settle(300);
        // done on the final timeout cycle wins
        set_random(0);
        force_lat = TIMEOUT;
        settle(300);
        // done one cycle too late is ignored
        set_random(2);
        force_lat = TIMEOUT + 1;
        settle(300);
        // en low blocks grants
        en = 1'b0;
        set_random(1);
        repeat (20) tick();
        en = 1'b1;
        settle(100);
        // en dropped mid-WAIT still completes
        set_random(2);
        force_lat = 8;
        repeat (4) tick();
        en = 1'b0;
        settle(100);
        en = 1'b1;
        // asynchronous reset during WAIT
        set_random(3);
        force_lat = 20;
        repeat (5) tick();
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        req    = '0;
        m_done = 1'b0;
        model_reset();
        #1;
        reset_checks("arst");
        tick();
        rst_n = 1'b1;
        // randomized traffic
        rand_mode = 1;
        repeat (3000) tick();
        rand_mode = 0;
        en = 1'b1;
        settle(800);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iic_arbiter.md
# iic_arbiter

Round-robin scheduler that shares one `iic_master` between up to N register-access clients, such as the PCF8563 RTC interface and other on-board I2C peripherals. It accepts one single-register read or write request per client, grants the bus fairly, and sequences the master's `start`/`done` handshake. It returns read data and completion to the granted client, and recovers the master with a timed reset if a transfer never completes. It sits between client controllers and the single `iic_master` instance on the APDAQ I2C bus.

## Interface
- `N`, 4: number of clients, 2..8.
- `TIMEOUT`, 1000000: maximum clk cycles spent waiting for `m_done` before abort.
- `RST_LEN`, 4: cycles `m_rst_n` is held low on abort.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  when low, no new grant is issued; an in-flight transfer still completes.
- `req`  in  N  per-client level request; held with its fields until `ack` or `err`.
- `req_dev_addr`  in  N×7  per-client 7-bit device address.
- `req_reg_addr`  in  N×8  per-client register address.
- `req_w`  in  N  1 = write, 0 = read.
- `req_wd`  in  N×8  write data.
- `ack`  out  N  one-cycle completion pulse to the granted client.
- `err`  out  N  one-cycle timeout pulse to the granted client.
- `rdata`  out  8  read data; valid while `ack` is high, held until next completion.
- `busy`  out  1  high in any state other than IDLE.
- `m_start`  out  1  one-cycle start pulse to `iic_master`.
- `m_dev_addr`, `m_reg_addr`, `m_w`, `m_wd`  out  7/8/1/8  registered request fields, stable from `m_start` until return to IDLE.
- `m_rdata`  in  8  master read data.
- `m_done`  in  1  master completion pulse.
- `m_rst_n`  out  1  active-low reset to `iic_master`.

## Operation
- Reset values:
  - state = IDLE.
  - `ack`, `err`, `m_start` = 0.
  - `busy` = 0.
  - `rdata` and all `m_*` fields = 0.
  - `m_rst_n` = 1.
  - round-robin pointer `last` = N-1.
  - timeout counter = 0.
- The FSM has five states: IDLE, START, WAIT, RESP, RECOVER.
- **IDLE**
  - If `en` and any `req` bit is set, grant `g` = the first set bit searching from `last+1` modulo N.
  - Register `g` and the client's fields into `m_*`; go to START.
  - Otherwise stay in IDLE.
- **START**
  - `m_start`=1 for exactly this cycle.
  - Clear the timeout counter; go to WAIT.
- **WAIT**
  - On `m_done`: latch `m_rdata` into `rdata`; go to RESP.
  - Otherwise, when the counter reaches `TIMEOUT`-1: `err[g]`=1 for one cycle; go to RECOVER.
  - Otherwise increment the counter.
  - If `m_done` and the timeout fall in the same cycle, `m_done` wins and no `err` is raised.
- **RESP**
  - `ack[g]`=1 for this cycle only; `last`←`g`; go to IDLE.
- **RECOVER**
  - `m_rst_n`=0 for `RST_LEN` cycles; `last`←`g`; then go to IDLE.
- `m_done` outside WAIT is ignored.
- Client rule: clear `req` at the clock edge that samples `ack` or `err` high. A `req` still high in the following IDLE cycle is treated as a new request.
- Changes to `req` or fields of a granted client after IDLE have no effect until the next grant.
- `en` falling during START, WAIT, RESP or RECOVER does not abort the sequence.
- Asynchronous reset mid-transfer drops everything without `ack`/`err`. Clients share `rst_n` and reset with the arbiter.

## Timing
- `req` high in IDLE at cycle t:
  - `m_start` at t+1.
  - `m_done` at cycle d gives `ack` and valid `rdata` at d+1.
  - IDLE again at d+2.
- Minimum gap between consecutive `m_start` pulses: 3 cycles after `m_done`.
- Timeout:
  - `err` is asserted exactly `TIMEOUT` cycles after the first WAIT cycle.
  - `m_rst_n` low for `RST_LEN` cycles starting the cycle after `err`.
  - Next grant possible `RST_LEN`+1 cycles after `err`.
- Timeout counter width: `$clog2(TIMEOUT+1)`.
- All outputs are registered.

## Structure
- Package `iic_arb_pkg` contains:
  - the state enum `iic_arb_state_t` {IDLE, START, WAIT, RESP, RECOVER};
  - a typedef `iic_req_t` struct {dev_addr[6:0], reg_addr[7:0], w, wd[7:0]};
  - a `localparam` for the default `RST_LEN`.
- Sub-module `rr_pick`: combinational round-robin selector. Inputs are `req[N]` and `last`; outputs are `valid` and the grant index `g`. It is reused by other shared-bus blocks.

## Test plan
- Single client 0 write, dev 0x51 reg 0x01 wd 0xC0 → `m_start` one cycle later with those fields; `m_done` → `ack[0]` next cycle, `busy` low after.
- Client 2 read; master returns 0x37 → `rdata`=0x37 coincident with `ack[2]`; no `ack` to any other client.
- `req`=4'b1111 held continuously with `last`=3 → grant order 0,1,2,3,0; each client acked once per round.
- `m_done` never arrives, `TIMEOUT`=50 → `err[g]` 50 cycles after WAIT entry, `m_rst_n` low 4 cycles, next pending client granted afterwards.
- `m_done` coincident with the final timeout cycle → `ack` asserted, no `err`, `m_rst_n` stays high.
- `en` low with pending `req` → no `m_start`; `en` dropped mid-WAIT → transfer completes with `ack`; `rst_n` pulse in WAIT → all outputs return to reset values immediately.
